product_accumulator: RTL

//   Downstream stage of the 4x4 array multiplier: consumes its 8-bit products over a

---
 rtl/product_accumulator_if.sv | 28 ++
 rtl/product_accumulator.sv | 138 +++++++++++++
 2 files changed

// File: rtl/product_accumulator_if.sv
// Stream bundle between the multiplier and the product accumulator: a product
// input stream and a burst-result output stream, both valid/ready.
interface product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;
    logic              out_trunc;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf, out_trunc
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf, out_trunc
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums each burst of unsigned products into a saturating total and presents the
// total with its term count and overflow/truncation flags on a valid/ready port.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    product_accumulator_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_T   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              trunc_q, trunc_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept_s;
    logic              out_hs_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic [ACC_W:0]    add_s;

    // Returns {carry, sum}; on carry the sum is pinned at all-ones so a
    // saturated burst stays saturated.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] b);
        logic [ACC_W:0] raw;
        raw = {1'b0, a} + (ACC_W+1)'(b);
        if (raw[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = raw;
        end
    endfunction

    assign accept_s  = bus.in_valid & in_ready_q;
    assign out_hs_s  = out_valid_q & bus.out_ready;
    assign cnt_inc_s = cnt_q + ONE_CNT;
    assign add_s     = sat_add(acc_q, bus.in_prod);

    // Next-state, datapath and registered-handshake decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    acc_d   = ACC_W'(bus.in_prod);
                    cnt_d   = ONE_CNT;
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                    if (bus.in_last) begin
                        state_d = DONE;
                    end else if (ONE_CNT == MAX_T) begin
                        state_d = DONE;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (accept_s) begin
                    acc_d = add_s[ACC_W-1:0];
                    cnt_d = cnt_inc_s;
                    ovf_d = ovf_q | add_s[ACC_W];
                    // in_last takes priority over the term limit
                    if (bus.in_last) begin
                        state_d = DONE;
                        trunc_d = 1'b0;
                    end else if (cnt_inc_s == MAX_T) begin
                        state_d = DONE;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            DONE: begin
                if (out_hs_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d != DONE);
        out_valid_d = (state_d == DONE);
    end

    // State, accumulator and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            trunc_q     <= trunc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_trunc = trunc_q;
endmodule
